// File: rtl/cmp_minmax_tracker.sv
// Streaming min/max reduction: tracks running minimum, maximum, first-occurrence
// indices and sample count per in_last-delimited frame, one registered result per frame.
module cmp_minmax_tracker #(
   parameter int WIDTH  = 32,
   parameter bit SIGNED = 1'b0,
   parameter int IDX_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_last,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [WIDTH-1:0]   res_min,
   output logic [WIDTH-1:0]   res_max,
   output logic [IDX_W-1:0]   res_min_idx,
   output logic [IDX_W-1:0]   res_max_idx,
   output logic [IDX_W:0]     res_count,
   output logic               res_trunc
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t             state_r, state_s;
   logic [WIDTH-1:0]   min_r, min_s, max_r, max_s;
   logic [IDX_W-1:0]   min_idx_r, min_idx_s, max_idx_r, max_idx_s;
   logic [IDX_W:0]     count_r, count_s;
   logic               trunc_r, trunc_s;
   logic               res_valid_r, res_valid_s;
   logic               accept_s;
   logic [IDX_W-1:0]   idx_s;

   function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED) begin
         less_than = $signed(a) < $signed(b);
      end else begin
         less_than = a < b;
      end
   endfunction

   // Ready is a pure function of state, forced low while reset is held
   assign in_ready  = rst_n & (state_r != ST_HOLD);
   assign accept_s  = in_valid & (state_r != ST_HOLD);
   assign idx_s     = count_r[IDX_W-1:0];

   // Next-state and next-result computation; clr overrides accept and handshake
   always_comb begin
      state_s     = state_r;
      min_s       = min_r;
      max_s       = max_r;
      min_idx_s   = min_idx_r;
      max_idx_s   = max_idx_r;
      count_s     = count_r;
      trunc_s     = trunc_r;
      res_valid_s = res_valid_r;
      if (clr) begin
         state_s     = ST_IDLE;
         res_valid_s = 1'b0;
         trunc_s     = 1'b0;
         count_s     = '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  min_s     = in_data;
                  max_s     = in_data;
                  min_idx_s = '0;
                  max_idx_s = '0;
                  count_s   = {{IDX_W{1'b0}}, 1'b1};
                  trunc_s   = 1'b0;
                  if (in_last) begin
                     state_s     = ST_HOLD;
                     res_valid_s = 1'b1;
                  end else begin
                     state_s = ST_RUN;
                  end
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (accept_s) begin
                  if (less_than(in_data, min_r)) begin
                     min_s     = in_data;
                     min_idx_s = idx_s;
                  end else begin
                     min_s = min_r;
                  end
                  if (less_than(max_r, in_data)) begin
                     max_s     = in_data;
                     max_idx_s = idx_s;
                  end else begin
                     max_s = max_r;
                  end
                  count_s = count_r + {{IDX_W{1'b0}}, 1'b1};
                  if (in_last) begin
                     state_s     = ST_HOLD;
                     res_valid_s = 1'b1;
                  end else if (idx_s == {IDX_W{1'b1}}) begin
                     // Frame hit the length limit: close it and flag truncation
                     state_s     = ST_HOLD;
                     res_valid_s = 1'b1;
                     trunc_s     = 1'b1;
                  end else begin
                     state_s = ST_RUN;
                  end
               end else begin
                  state_s = ST_RUN;
               end
            end
            ST_HOLD: begin
               if (res_ready) begin
                  state_s     = ST_IDLE;
                  res_valid_s = 1'b0;
                  trunc_s     = 1'b0;
               end else begin
                  state_s = ST_HOLD;
               end
            end
            default: begin
               state_s     = ST_IDLE;
               res_valid_s = 1'b0;
               trunc_s     = 1'b0;
            end
         endcase
      end
   end

   // State and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         min_r       <= '0;
         max_r       <= '0;
         min_idx_r   <= '0;
         max_idx_r   <= '0;
         count_r     <= '0;
         trunc_r     <= 1'b0;
         res_valid_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         min_r       <= min_s;
         max_r       <= max_s;
         min_idx_r   <= min_idx_s;
         max_idx_r   <= max_idx_s;
         count_r     <= count_s;
         trunc_r     <= trunc_s;
         res_valid_r <= res_valid_s;
      end
   end

   assign res_valid   = res_valid_r;
   assign res_min     = min_r;
   assign res_max     = max_r;
   assign res_min_idx = min_idx_r;
   assign res_max_idx = max_idx_r;
   assign res_count   = count_r;
   assign res_trunc   = trunc_r;

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
// Bench for cmp_minmax_tracker: three configurations (unsigned, signed, IDX_W=2)
// checked against a frame-level reference model.
module tb_cmp_minmax_tracker;

   typedef struct packed {
      logic [7:0] mn;
      logic [7:0] mx;
      logic [7:0] mni;
      logic [7:0] mxi;
      logic [8:0] cnt;
      logic       tr;
   } res_t;

   logic       clk = 1'b0;
   logic       rst_n, clr, in_last;
   logic [7:0] in_data;
   logic [2:0] in_valid, res_ready, in_ready, res_valid, res_trunc;
   logic [7:0] res_min [3];
   logic [7:0] res_max [3];
   logic [7:0] mni0, mni1, mxi0, mxi1;
   logic [1:0] mni2, mxi2;
   logic [8:0] cnt0, cnt1;
   logic [2:0] cnt2;
   logic [1:0] sel;
   res_t       obs;
   res_t       rq[$];
   res_t       exp_q[$];
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   cmp_minmax_tracker #(.WIDTH(8), .SIGNED(1'b0), .IDX_W(8)) u0 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data), .in_last(in_last), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
      .res_min(res_min[0]), .res_max(res_max[0]), .res_min_idx(mni0), .res_max_idx(mxi0),
      .res_count(cnt0), .res_trunc(res_trunc[0]));

   cmp_minmax_tracker #(.WIDTH(8), .SIGNED(1'b1), .IDX_W(8)) u1 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data), .in_last(in_last), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
      .res_min(res_min[1]), .res_max(res_max[1]), .res_min_idx(mni1), .res_max_idx(mxi1),
      .res_count(cnt1), .res_trunc(res_trunc[1]));

   cmp_minmax_tracker #(.WIDTH(8), .SIGNED(1'b0), .IDX_W(2)) u2 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data), .in_last(in_last), .res_valid(res_valid[2]), .res_ready(res_ready[2]),
      .res_min(res_min[2]), .res_max(res_max[2]), .res_min_idx(mni2), .res_max_idx(mxi2),
      .res_count(cnt2), .res_trunc(res_trunc[2]));

   // Uniform view of the selected instance's result port
   always_comb begin
      obs = '0;
      case (sel)
         2'd0: begin
            obs.mn = res_min[0]; obs.mx = res_max[0]; obs.mni = mni0; obs.mxi = mxi0;
            obs.cnt = cnt0; obs.tr = res_trunc[0];
         end
         2'd1: begin
            obs.mn = res_min[1]; obs.mx = res_max[1]; obs.mni = mni1; obs.mxi = mxi1;
            obs.cnt = cnt1; obs.tr = res_trunc[1];
         end
         2'd2: begin
            obs.mn = res_min[2]; obs.mx = res_max[2]; obs.mni = {6'd0, mni2}; obs.mxi = {6'd0, mxi2};
            obs.cnt = {6'd0, cnt2}; obs.tr = res_trunc[2];
         end
         default: obs = '0;
      endcase
   end

   // Capture each result handshake of the selected instance
   always @(negedge clk) begin
      if (rst_n && res_valid[sel] && res_ready[sel]) rq.push_back(obs);
   end

   function automatic int val(input logic [7:0] x, input bit sg);
      return sg ? int'($signed(x)) : int'(x);
   endfunction

   // Reference: split the sample list into chunks of at most 2**IDX_W and reduce each
   function automatic void model(input logic [1:0] s_sel, input logic [7:0] s[$]);
      int lim = (s_sel == 2'd2) ? 4 : 256;
      bit sg = (s_sel == 2'd1);
      int start = 0;
      while (start < s.size()) begin
         int n;
         res_t r;
         n = s.size() - start;
         if (n > lim) n = lim;
         r = '0;
         r.mn = s[start];
         r.mx = s[start];
         for (int i = 1; i < n; i++) begin
            if (val(s[start+i], sg) < val(r.mn, sg)) begin r.mn = s[start+i]; r.mni = 8'(i); end
            if (val(s[start+i], sg) > val(r.mx, sg)) begin r.mx = s[start+i]; r.mxi = 8'(i); end
         end
         r.cnt = 9'(n);
         r.tr  = (start + n < s.size());
         exp_q.push_back(r);
         start += n;
      end
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
      end
   endtask

   task automatic send(input logic [1:0] s_sel, input logic [7:0] d, input logic last);
      int n = 0;
      in_data = d;
      in_last = last;
      in_valid[s_sel] = 1'b1;
      while (!in_ready[s_sel] && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
      step();
      in_valid[s_sel] = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while (rq.size() < exp_q.size() && k < 50) begin
         step();
         k++;
      end
      chk({tag, ".nres"}, 32'(rq.size()), 32'(exp_q.size()));
      while (rq.size() > 0 && exp_q.size() > 0) begin
         res_t o, e;
         o = rq.pop_front();
         e = exp_q.pop_front();
         chk({tag, ".min"}, 32'(o.mn), 32'(e.mn));
         chk({tag, ".max"}, 32'(o.mx), 32'(e.mx));
         chk({tag, ".min_idx"}, 32'(o.mni), 32'(e.mni));
         chk({tag, ".max_idx"}, 32'(o.mxi), 32'(e.mxi));
         chk({tag, ".count"}, 32'(o.cnt), 32'(e.cnt));
         chk({tag, ".trunc"}, 32'(o.tr), 32'(e.tr));
      end
      rq.delete();
      exp_q.delete();
   endtask

   task automatic run_frame(input string tag, input logic [1:0] s_sel, input logic [7:0] s[$], input bit gaps);
      sel = s_sel;
      model(s_sel, s);
      for (int i = 0; i < s.size(); i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) step();
         send(s_sel, s[i], (i == s.size() - 1));
      end
      chk({tag, ".lat_valid"}, 32'(res_valid[s_sel]), 32'd1);
      chk({tag, ".hold_ready"}, 32'(in_ready[s_sel]), 32'd0);
      step();
      chk({tag, ".bubble_ready"}, 32'(in_ready[s_sel]), 32'd1);
      chk({tag, ".bubble_valid"}, 32'(res_valid[s_sel]), 32'd0);
      drain(tag);
   endtask

   initial begin
      logic [7:0] q[$];
      rst_n = 1'b0; clr = 1'b0; in_last = 1'b0; in_data = 8'd0;
      in_valid = 3'b000; res_ready = 3'b111; sel = 2'd0;
      #3;
      chk("rst.in_ready", 32'(in_ready), 32'd0);
      chk("rst.res_valid", 32'(res_valid), 32'd0);
      chk("rst.min", 32'(obs.mn), 32'd0);
      chk("rst.count", 32'(obs.cnt), 32'd0);
      step(); step();
      rst_n = 1'b1;
      step();
      chk("rst.release_ready", 32'(in_ready), 32'd7);

      q = '{8'd5, 8'd9, 8'd2, 8'd9, 8'd2};
      run_frame("unsigned", 2'd0, q, 1'b1);
      q = '{8'h7F, 8'h80, 8'h00};
      run_frame("signed", 2'd1, q, 1'b1);
      run_frame("same_unsigned", 2'd0, q, 1'b1);
      q = '{8'h33};
      run_frame("single", 2'd0, q, 1'b0);
      q = '{8'h44};
      run_frame("b2b", 2'd0, q, 1'b0);

      // Backpressure: result held while in_valid is asserted in HOLD
      sel = 2'd0;
      res_ready[0] = 1'b0;
      q = '{8'h10, 8'h05, 8'h20};
      model(2'd0, q);
      foreach (q[i]) send(2'd0, q[i], (i == 2));
      in_data = 8'hEE; in_last = 1'b1; in_valid[0] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         chk("bp.valid", 32'(res_valid[0]), 32'd1);
         chk("bp.ready", 32'(in_ready[0]), 32'd0);
         chk("bp.min", 32'(obs.mn), 32'h05);
         chk("bp.count", 32'(obs.cnt), 32'd3);
         step();
      end
      res_ready[0] = 1'b1; in_valid[0] = 1'b0;
      step();
      chk("bp.rel_valid", 32'(res_valid[0]), 32'd0);
      chk("bp.rel_ready", 32'(in_ready[0]), 32'd1);
      drain("bp");
      q = '{8'h01};
      run_frame("after_bp", 2'd0, q, 1'b0);

      q = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
      run_frame("trunc", 2'd2, q, 1'b1);

      // clr mid-frame together with a presented sample
      sel = 2'd0;
      send(2'd0, 8'h40, 1'b0); send(2'd0, 8'h41, 1'b0); send(2'd0, 8'h42, 1'b0);
      in_data = 8'h55; in_last = 1'b1; in_valid[0] = 1'b1; clr = 1'b1;
      step();
      clr = 1'b0; in_valid[0] = 1'b0;
      chk("clr.valid", 32'(res_valid[0]), 32'd0);
      chk("clr.ready", 32'(in_ready[0]), 32'd1);
      chk("clr.count", 32'(cnt0), 32'd0);
      step();
      chk("clr.nres", 32'(rq.size()), 32'd0);
      q = '{8'd7, 8'd3};
      run_frame("post_clr", 2'd0, q, 1'b1);

      // Asynchronous reset while a result is held
      res_ready[0] = 1'b0;
      send(2'd0, 8'h21, 1'b1);
      chk("arst.pre_valid", 32'(res_valid[0]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.valid", 32'(res_valid[0]), 32'd0);
      chk("arst.ready", 32'(in_ready[0]), 32'd0);
      chk("arst.min", 32'(obs.mn), 32'd0);
      #3 rst_n = 1'b1;
      res_ready[0] = 1'b1;
      step();
      chk("arst.rel_ready", 32'(in_ready[0]), 32'd1);
      chk("arst.nres", 32'(rq.size()), 32'd0);
      rq.delete();

      // Randomized frames across all three configurations
      for (int f = 0; f < 24; f++) begin
         int len;
         bit narrow;
         len = $urandom_range(1, 10);
         narrow = $urandom_range(0, 1) == 1;
         q.delete();
         for (int i = 0; i < len; i++) q.push_back(narrow ? 8'($urandom_range(0, 7)) : 8'($urandom_range(0, 255)));
         run_frame("rand", 2'(f % 3), q, 1'b1);
      end
      q.delete();
      for (int i = 0; i < 260; i++) q.push_back(8'($urandom_range(0, 255)));
      run_frame("long", 2'd0, q, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
